// File: rtl/mips_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_ctrl_pkg
//  Description : Opcode, funct and ALU-code constants plus the control
//                bundles carried down the D->E->M->W pipeline registers.
//  Revision    : 1.0  initial release
// ============================================================================
package mips_ctrl_pkg;

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_BNE   = 6'b000101;
    localparam logic [5:0] c_OP_J     = 6'b000010;

    localparam logic [5:0] c_FN_NOP   = 6'b000000;
    localparam logic [5:0] c_FN_ADD   = 6'b100000;
    localparam logic [5:0] c_FN_SUB   = 6'b100010;
    localparam logic [5:0] c_FN_AND   = 6'b100100;
    localparam logic [5:0] c_FN_OR    = 6'b100101;
    localparam logic [5:0] c_FN_SLT   = 6'b101010;
    localparam logic [5:0] c_FN_MULT  = 6'b011000;

    localparam logic [2:0] c_ALU_AND  = 3'b000;
    localparam logic [2:0] c_ALU_OR   = 3'b001;
    localparam logic [2:0] c_ALU_ADD  = 3'b010;
    localparam logic [2:0] c_ALU_MULT = 3'b101;
    localparam logic [2:0] c_ALU_SUB  = 3'b110;
    localparam logic [2:0] c_ALU_SLT  = 3'b111;

    typedef struct packed {
        logic       regwrite;
        logic       memtoreg;
        logic       memwrite;
        logic       alusrc;
        logic       regdst;
        logic [2:0] alucontrol;
    } ctrl_e_t;

    typedef struct packed {
        logic regwrite;
        logic memtoreg;
        logic memwrite;
    } ctrl_m_t;

    typedef struct packed {
        logic regwrite;
        logic memtoreg;
    } ctrl_w_t;

endpackage
`default_nettype wire

// File: rtl/hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_unit
//  Description : Purely combinational stall / flush / forwarding selection.
//                Inputs : D/E source specifiers, E/M/W destinations and the
//                         stage write/load flags.
//                Outputs: stall_f/stall_d/flush_e, D comparator forwards,
//                         E ALU operand forward selects (00 rf, 01 W, 10 M).
//  Revision    : 1.0  initial release
// ============================================================================
module hazard_unit #(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  i_branch_d,
    input  logic [REG_ADDR_W-1:0] i_rs_d,
    input  logic [REG_ADDR_W-1:0] i_rt_d,
    input  logic [REG_ADDR_W-1:0] i_rs_e,
    input  logic [REG_ADDR_W-1:0] i_rt_e,
    input  logic [REG_ADDR_W-1:0] i_write_reg_e,
    input  logic [REG_ADDR_W-1:0] i_write_reg_m,
    input  logic [REG_ADDR_W-1:0] i_write_reg_w,
    input  logic                  i_regwrite_e,
    input  logic                  i_memtoreg_e,
    input  logic                  i_regwrite_m,
    input  logic                  i_memtoreg_m,
    input  logic                  i_regwrite_w,
    output logic                  o_stall_f,
    output logic                  o_stall_d,
    output logic                  o_flush_e,
    output logic                  o_forward_ad,
    output logic                  o_forward_bd,
    output logic [1:0]            o_forward_ae,
    output logic [1:0]            o_forward_be
);

    // Destination matches either D source; register 0 never counts.
    function automatic logic hits_d(input logic [REG_ADDR_W-1:0] dst,
                                    input logic [REG_ADDR_W-1:0] rs,
                                    input logic [REG_ADDR_W-1:0] rt);
        return (dst != '0) && ((dst == rs) || (dst == rt));
    endfunction

    // M result has priority over W since it is the younger value.
    function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] src,
                                           input logic [REG_ADDR_W-1:0] dst_m,
                                           input logic                  we_m,
                                           input logic [REG_ADDR_W-1:0] dst_w,
                                           input logic                  we_w);
        if ((src != '0) && (src == dst_m) && we_m) return 2'b10;
        if ((src != '0) && (src == dst_w) && we_w) return 2'b01;
        return 2'b00;
    endfunction

    logic w_lwstall;
    logic w_brstall;
    logic w_stall;

    assign w_lwstall = i_memtoreg_e && hits_d(i_write_reg_e, i_rs_d, i_rt_d);
    assign w_brstall = i_branch_d &&
                       ((i_regwrite_e && hits_d(i_write_reg_e, i_rs_d, i_rt_d)) ||
                        (i_memtoreg_m && hits_d(i_write_reg_m, i_rs_d, i_rt_d)));
    assign w_stall   = w_lwstall || w_brstall;

    assign o_stall_f = w_stall;
    assign o_stall_d = w_stall;
    assign o_flush_e = w_stall;

    assign o_forward_ad = (i_rs_d != '0) && (i_rs_d == i_write_reg_m) && i_regwrite_m;
    assign o_forward_bd = (i_rt_d != '0) && (i_rt_d == i_write_reg_m) && i_regwrite_m;

    assign o_forward_ae = fwd_sel(i_rs_e, i_write_reg_m, i_regwrite_m, i_write_reg_w, i_regwrite_w);
    assign o_forward_be = fwd_sel(i_rt_e, i_write_reg_m, i_regwrite_m, i_write_reg_w, i_regwrite_w);

endmodule
`default_nettype wire

// File: rtl/pipeline_control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_control_unit
//  Description : D-stage decode of op/funct for the 5-stage MIPS pipeline,
//                control carried through D->E->M->W registers, plus hazard
//                handling via hazard_unit.
//                Inputs : clk, reset, op/funct, equal_d, D/E specifiers,
//                         E/M/W destination registers.
//                Outputs: pcsrc/jump/branch/illegal (D), stalls/flush,
//                         forward selects, E/M/W stage controls.
//  Revision    : 1.0  initial release
// ============================================================================
module pipeline_control_unit
    import mips_ctrl_pkg::*;
#(
    parameter int ALUCTRL_W  = 3,
    parameter int REG_ADDR_W = 5,
    parameter int EN_BNE     = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [5:0]            op,
    input  logic [5:0]            funct,
    input  logic                  equal_d,
    input  logic [REG_ADDR_W-1:0] rs_d,
    input  logic [REG_ADDR_W-1:0] rt_d,
    input  logic [REG_ADDR_W-1:0] rs_e,
    input  logic [REG_ADDR_W-1:0] rt_e,
    input  logic [REG_ADDR_W-1:0] write_reg_e,
    input  logic [REG_ADDR_W-1:0] write_reg_m,
    input  logic [REG_ADDR_W-1:0] write_reg_w,
    output logic                  pcsrc_d,
    output logic                  jump_d,
    output logic                  branch_d,
    output logic                  illegal_d,
    output logic                  stall_f,
    output logic                  stall_d,
    output logic                  flush_e,
    output logic                  forward_ad,
    output logic                  forward_bd,
    output logic [1:0]            forward_ae,
    output logic [1:0]            forward_be,
    output logic                  regdst_e,
    output logic                  alusrc_e,
    output logic                  memtoreg_e,
    output logic                  regwrite_e,
    output logic [ALUCTRL_W-1:0]  alucontrol_e,
    output logic                  regwrite_m,
    output logic                  memtoreg_m,
    output logic                  memwrite_m,
    output logic                  regwrite_w,
    output logic                  memtoreg_w
);

    ctrl_e_t w_dec;
    logic    w_branch;
    logic    w_jump;
    logic    w_illegal;
    logic    w_stall_d;
    logic    w_flush_e;

    ctrl_e_t r_ctrl_e;
    ctrl_m_t r_ctrl_m;
    ctrl_w_t r_ctrl_w;

    // Unsupported encodings fall out of the case with every enable zero,
    // so an illegal instruction travels down the pipe as a bubble.
    always_comb begin
        w_dec     = '0;
        w_branch  = 1'b0;
        w_jump    = 1'b0;
        w_illegal = 1'b0;
        case (op)
            c_OP_RTYPE: begin
                w_dec.regwrite = 1'b1;
                w_dec.regdst   = 1'b1;
                case (funct)
                    c_FN_ADD:  w_dec.alucontrol = c_ALU_ADD;
                    c_FN_SUB:  w_dec.alucontrol = c_ALU_SUB;
                    c_FN_AND:  w_dec.alucontrol = c_ALU_AND;
                    c_FN_OR:   w_dec.alucontrol = c_ALU_OR;
                    c_FN_SLT:  w_dec.alucontrol = c_ALU_SLT;
                    c_FN_MULT: w_dec.alucontrol = c_ALU_MULT;
                    c_FN_NOP:  w_dec.alucontrol = c_ALU_AND;
                    default: begin
                        w_dec     = '0;
                        w_illegal = 1'b1;
                    end
                endcase
            end
            c_OP_LW: begin
                w_dec.regwrite   = 1'b1;
                w_dec.memtoreg   = 1'b1;
                w_dec.alusrc     = 1'b1;
                w_dec.alucontrol = c_ALU_ADD;
            end
            c_OP_SW: begin
                w_dec.memwrite   = 1'b1;
                w_dec.alusrc     = 1'b1;
                w_dec.alucontrol = c_ALU_ADD;
            end
            c_OP_ADDI: begin
                w_dec.regwrite   = 1'b1;
                w_dec.alusrc     = 1'b1;
                w_dec.alucontrol = c_ALU_ADD;
            end
            c_OP_BEQ: begin
                w_branch         = 1'b1;
                w_dec.alucontrol = c_ALU_SUB;
            end
            c_OP_BNE: begin
                if (EN_BNE != 0) begin
                    w_branch         = 1'b1;
                    w_dec.alucontrol = c_ALU_SUB;
                end else begin
                    w_illegal = 1'b1;
                end
            end
            c_OP_J:  w_jump    = 1'b1;
            default: w_illegal = 1'b1;
        endcase
    end

    hazard_unit #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_hazard (
        .i_branch_d    (w_branch),
        .i_rs_d        (rs_d),
        .i_rt_d        (rt_d),
        .i_rs_e        (rs_e),
        .i_rt_e        (rt_e),
        .i_write_reg_e (write_reg_e),
        .i_write_reg_m (write_reg_m),
        .i_write_reg_w (write_reg_w),
        .i_regwrite_e  (r_ctrl_e.regwrite),
        .i_memtoreg_e  (r_ctrl_e.memtoreg),
        .i_regwrite_m  (r_ctrl_m.regwrite),
        .i_memtoreg_m  (r_ctrl_m.memtoreg),
        .i_regwrite_w  (r_ctrl_w.regwrite),
        .o_stall_f     (stall_f),
        .o_stall_d     (w_stall_d),
        .o_flush_e     (w_flush_e),
        .o_forward_ad  (forward_ad),
        .o_forward_bd  (forward_bd),
        .o_forward_ae  (forward_ae),
        .o_forward_be  (forward_be)
    );

    // A stalled branch must not redirect the PC: its operands are not ready.
    assign pcsrc_d = !w_stall_d &&
                     (w_jump || (w_branch && ((op == c_OP_BEQ) ? equal_d : !equal_d)));

    // Reset has priority over flush; E->M and M->W never stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ctrl_e <= '0;
            r_ctrl_m <= '0;
            r_ctrl_w <= '0;
        end else begin
            r_ctrl_e          <= w_flush_e ? '0 : w_dec;
            r_ctrl_m.regwrite <= r_ctrl_e.regwrite;
            r_ctrl_m.memtoreg <= r_ctrl_e.memtoreg;
            r_ctrl_m.memwrite <= r_ctrl_e.memwrite;
            r_ctrl_w.regwrite <= r_ctrl_m.regwrite;
            r_ctrl_w.memtoreg <= r_ctrl_m.memtoreg;
        end
    end

    assign jump_d       = w_jump;
    assign branch_d     = w_branch;
    assign illegal_d    = w_illegal;
    assign stall_d      = w_stall_d;
    assign flush_e      = w_flush_e;
    assign regdst_e     = r_ctrl_e.regdst;
    assign alusrc_e     = r_ctrl_e.alusrc;
    assign memtoreg_e   = r_ctrl_e.memtoreg;
    assign regwrite_e   = r_ctrl_e.regwrite;
    assign alucontrol_e = ALUCTRL_W'(r_ctrl_e.alucontrol);
    assign regwrite_m   = r_ctrl_m.regwrite;
    assign memtoreg_m   = r_ctrl_m.memtoreg;
    assign memwrite_m   = r_ctrl_m.memwrite;
    assign regwrite_w   = r_ctrl_w.regwrite;
    assign memtoreg_w   = r_ctrl_w.memtoreg;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipeline_control_unit
//  Description : Self-checking bench for pipeline_control_unit. Drives
//                directed sequences followed by random instruction streams
//                and compares against an instruction-level pipeline model.
//                A second instance built with bne disabled shares the inputs.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pipeline_control_unit;

    logic       clk = 1'b0;
    logic       r_reset;
    logic [5:0] r_op, r_funct;
    logic       r_equal;
    logic [4:0] r_rs_d, r_rt_d, r_rs_e, r_rt_e, r_wr_e, r_wr_m, r_wr_w;

    logic       w_pcsrc, w_jump, w_branch, w_illegal, w_stall_f, w_stall_d, w_flush_e;
    logic       w_fad, w_fbd;
    logic [1:0] w_fae, w_fbe;
    logic       w_regdst_e, w_alusrc_e, w_memtoreg_e, w_regwrite_e;
    logic [2:0] w_aluctl_e;
    logic       w_regwrite_m, w_memtoreg_m, w_memwrite_m, w_regwrite_w, w_memtoreg_w;

    logic       n_pcsrc, n_jump, n_branch, n_illegal, n_stall_f, n_stall_d, n_flush_e;
    logic       n_fad, n_fbd;
    logic [1:0] n_fae, n_fbe;
    logic       n_regdst_e, n_alusrc_e, n_memtoreg_e, n_regwrite_e;
    logic [2:0] n_aluctl_e;
    logic       n_regwrite_m, n_memtoreg_m, n_memwrite_m, n_regwrite_w, n_memtoreg_w;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pipeline_control_unit u_dut (
        .clk(clk), .reset(r_reset), .op(r_op), .funct(r_funct), .equal_d(r_equal),
        .rs_d(r_rs_d), .rt_d(r_rt_d), .rs_e(r_rs_e), .rt_e(r_rt_e),
        .write_reg_e(r_wr_e), .write_reg_m(r_wr_m), .write_reg_w(r_wr_w),
        .pcsrc_d(w_pcsrc), .jump_d(w_jump), .branch_d(w_branch), .illegal_d(w_illegal),
        .stall_f(w_stall_f), .stall_d(w_stall_d), .flush_e(w_flush_e),
        .forward_ad(w_fad), .forward_bd(w_fbd), .forward_ae(w_fae), .forward_be(w_fbe),
        .regdst_e(w_regdst_e), .alusrc_e(w_alusrc_e), .memtoreg_e(w_memtoreg_e),
        .regwrite_e(w_regwrite_e), .alucontrol_e(w_aluctl_e),
        .regwrite_m(w_regwrite_m), .memtoreg_m(w_memtoreg_m), .memwrite_m(w_memwrite_m),
        .regwrite_w(w_regwrite_w), .memtoreg_w(w_memtoreg_w)
    );

    pipeline_control_unit #(.EN_BNE(0)) u_dut_nobne (
        .clk(clk), .reset(r_reset), .op(r_op), .funct(r_funct), .equal_d(r_equal),
        .rs_d(r_rs_d), .rt_d(r_rt_d), .rs_e(r_rs_e), .rt_e(r_rt_e),
        .write_reg_e(r_wr_e), .write_reg_m(r_wr_m), .write_reg_w(r_wr_w),
        .pcsrc_d(n_pcsrc), .jump_d(n_jump), .branch_d(n_branch), .illegal_d(n_illegal),
        .stall_f(n_stall_f), .stall_d(n_stall_d), .flush_e(n_flush_e),
        .forward_ad(n_fad), .forward_bd(n_fbd), .forward_ae(n_fae), .forward_be(n_fbe),
        .regdst_e(n_regdst_e), .alusrc_e(n_alusrc_e), .memtoreg_e(n_memtoreg_e),
        .regwrite_e(n_regwrite_e), .alucontrol_e(n_aluctl_e),
        .regwrite_m(n_regwrite_m), .memtoreg_m(n_memtoreg_m), .memwrite_m(n_memwrite_m),
        .regwrite_w(n_regwrite_w), .memtoreg_w(n_memtoreg_w)
    );

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model of the instruction in each stage, as its control vector:
    // [7] regwrite [6] memtoreg [5] memwrite [4] alusrc [3] regdst [2:0] alu.
    logic [7:0] s_e = '0, s_m = '0, s_w = '0;

    // Returns {illegal, jump, branch, ctrl[7:0]} straight from the instruction table.
    function automatic logic [10:0] ref_dec(input logic [5:0] o, input logic [5:0] f, input bit en_bne);
        case (o)
            6'b000000: begin
                case (f)
                    6'b100000: return {3'b000, 8'b1000_1010};
                    6'b100010: return {3'b000, 8'b1000_1110};
                    6'b100100: return {3'b000, 8'b1000_1000};
                    6'b100101: return {3'b000, 8'b1000_1001};
                    6'b101010: return {3'b000, 8'b1000_1111};
                    6'b011000: return {3'b000, 8'b1000_1101};
                    6'b000000: return {3'b000, 8'b1000_1000};
                    default:   return {3'b100, 8'h00};
                endcase
            end
            6'b100011: return {3'b000, 8'b1101_0010};
            6'b101011: return {3'b000, 8'b0011_0010};
            6'b001000: return {3'b000, 8'b1001_0010};
            6'b000100: return {3'b001, 8'b0000_0110};
            6'b000101: return en_bne ? {3'b001, 8'b0000_0110} : {3'b100, 8'h00};
            6'b000010: return {3'b010, 8'h00};
            default:   return {3'b100, 8'h00};
        endcase
    endfunction

    function automatic logic [1:0] ref_fwd(input logic [4:0] src);
        if (src != 0 && src == r_wr_m && s_m[7]) return 2'b10;
        if (src != 0 && src == r_wr_w && s_w[7]) return 2'b01;
        return 2'b00;
    endfunction

    // Check one cycle (inputs already applied after the falling edge), then
    // advance the model across the rising edge.
    task automatic step();
        logic [10:0] d, dn;
        logic uses_e, uses_m, lw_h, br_h, st, stn, pc, pcn;
        #1;
        d      = ref_dec(r_op, r_funct, 1'b1);
        dn     = ref_dec(r_op, r_funct, 1'b0);
        uses_e = (r_wr_e != 0) && (r_wr_e == r_rs_d || r_wr_e == r_rt_d);
        uses_m = (r_wr_m != 0) && (r_wr_m == r_rs_d || r_wr_m == r_rt_d);
        lw_h   = s_e[6] && uses_e;
        br_h   = (s_e[7] && uses_e) || (s_m[6] && uses_m);
        st     = lw_h || (d[8] && br_h);
        stn    = lw_h || (dn[8] && br_h);
        pc     = !st  && (d[9]  || (d[8]  && ((r_op == 6'b000100) ? r_equal : !r_equal)));
        pcn    = !stn && (dn[9] || (dn[8] && ((r_op == 6'b000100) ? r_equal : !r_equal)));

        check_value("illegal_d", 32'(w_illegal), 32'(d[10]));
        check_value("jump_d",    32'(w_jump),    32'(d[9]));
        check_value("branch_d",  32'(w_branch),  32'(d[8]));
        check_value("pcsrc_d",   32'(w_pcsrc),   32'(pc));
        check_value("stalls",    32'({w_stall_f, w_stall_d, w_flush_e}), 32'({st, st, st}));
        check_value("forward_d", 32'({w_fad, w_fbd}),
                    32'({r_rs_d != 0 && r_rs_d == r_wr_m && s_m[7],
                         r_rt_d != 0 && r_rt_d == r_wr_m && s_m[7]}));
        check_value("forward_ae", 32'(w_fae), 32'(ref_fwd(r_rs_e)));
        check_value("forward_be", 32'(w_fbe), 32'(ref_fwd(r_rt_e)));
        check_value("ctrl_e", 32'({w_regwrite_e, w_memtoreg_e, w_alusrc_e, w_regdst_e, w_aluctl_e}),
                    32'({s_e[7], s_e[6], s_e[4], s_e[3], s_e[2:0]}));
        check_value("ctrl_m", 32'({w_regwrite_m, w_memtoreg_m, w_memwrite_m}), 32'(s_m[7:5]));
        check_value("ctrl_w", 32'({w_regwrite_w, w_memtoreg_w}), 32'(s_w[7:6]));
        check_value("nobne_illegal", 32'(n_illegal), 32'(dn[10]));
        check_value("nobne_pcsrc",   32'(n_pcsrc),   32'(pcn));

        @(posedge clk);
        if (r_reset) begin
            s_e = '0; s_m = '0; s_w = '0;
        end else begin
            s_w = s_m;
            s_m = s_e;
            s_e = st ? 8'h00 : d[7:0];
        end
    endtask

    task automatic set_in(input logic rst, input logic [5:0] o, input logic [5:0] f, input logic eq,
                          input logic [4:0] rsd, input logic [4:0] rtd, input logic [4:0] rse,
                          input logic [4:0] rte, input logic [4:0] we, input logic [4:0] wm,
                          input logic [4:0] ww);
        @(negedge clk);
        r_reset = rst; r_op = o; r_funct = f; r_equal = eq;
        r_rs_d = rsd; r_rt_d = rtd; r_rs_e = rse; r_rt_e = rte;
        r_wr_e = we; r_wr_m = wm; r_wr_w = ww;
        step();
    endtask

    function automatic logic [5:0] pick_op();
        logic [5:0] ops [7] = '{6'b000000, 6'b100011, 6'b101011, 6'b001000,
                                6'b000100, 6'b000101, 6'b000010};
        int k = $urandom_range(0, 9);
        return (k < 7) ? ops[k] : 6'($urandom);
    endfunction

    function automatic logic [5:0] pick_funct();
        logic [5:0] fns [7] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                                6'b101010, 6'b011000, 6'b000000};
        int k = $urandom_range(0, 8);
        return (k < 7) ? fns[k] : 6'($urandom);
    endfunction

    initial begin
        r_reset = 1'b1; r_op = 6'b100011; r_funct = '0; r_equal = 1'b0;
        r_rs_d = '0; r_rt_d = '0; r_rs_e = '0; r_rt_e = '0;
        r_wr_e = '0; r_wr_m = '0; r_wr_w = '0;

        // Reset held with lw in D, then lw flows to W.
        set_in(1, 6'b100011, 6'h00, 0, 0, 0, 0, 0, 0, 0, 0);
        set_in(1, 6'b100011, 6'h00, 0, 0, 0, 0, 0, 0, 0, 0);
        set_in(0, 6'b100011, 6'h00, 0, 0, 0, 0, 0, 0, 0, 0);
        set_in(0, 6'b000000, 6'h00, 0, 0, 0, 0, 0, 0, 0, 0);
        set_in(0, 6'b000000, 6'h00, 0, 0, 0, 0, 0, 0, 0, 0);
        set_in(0, 6'b000000, 6'h00, 0, 0, 0, 0, 0, 0, 0, 0);
        // add $3,$1,$2 ; sub $4,$3,$5 -> M forward; then nop gap -> W forward.
        set_in(0, 6'b000000, 6'b100000, 0, 1, 2, 0, 0, 0, 0, 0);
        set_in(0, 6'b000000, 6'b100010, 0, 3, 5, 1, 2, 3, 0, 0);
        set_in(0, 6'b000000, 6'b000000, 0, 0, 0, 3, 5, 4, 3, 0);
        set_in(0, 6'b000000, 6'b100000, 0, 1, 2, 0, 0, 0, 4, 3);
        set_in(0, 6'b000000, 6'b000000, 0, 0, 0, 1, 2, 3, 0, 4);
        set_in(0, 6'b000000, 6'b100010, 0, 3, 5, 0, 0, 0, 3, 0);
        set_in(0, 6'b000000, 6'b000000, 0, 0, 0, 3, 5, 4, 0, 3);
        // lw $2 in E with add $4,$2,$1 in D: one-cycle stall and bubble.
        set_in(0, 6'b100011, 6'h00, 0, 1, 2, 0, 0, 0, 0, 0);
        set_in(0, 6'b000000, 6'b100000, 0, 2, 1, 1, 2, 2, 0, 0);
        set_in(0, 6'b000000, 6'b100000, 0, 2, 1, 0, 0, 0, 2, 0);
        set_in(0, 6'b000000, 6'b000000, 0, 0, 0, 2, 1, 4, 0, 2);
        // beq taken, then beq behind an E-stage writer of $1.
        set_in(0, 6'b000100, 6'h00, 1, 1, 1, 0, 0, 0, 0, 0);
        set_in(0, 6'b000000, 6'b100000, 0, 2, 3, 0, 0, 0, 0, 0);
        set_in(0, 6'b000100, 6'h00, 1, 1, 1, 2, 3, 1, 0, 0);
        set_in(0, 6'b000100, 6'h00, 1, 1, 1, 0, 0, 0, 1, 0);
        // bne not-equal, illegal op, illegal funct.
        set_in(0, 6'b000101, 6'h00, 0, 1, 2, 0, 0, 0, 0, 0);
        set_in(0, 6'b111111, 6'h00, 0, 0, 0, 0, 0, 0, 0, 0);
        set_in(0, 6'b000000, 6'b111111, 0, 0, 0, 0, 0, 0, 0, 0);
        set_in(0, 6'b000000, 6'h00, 0, 0, 0, 0, 0, 0, 0, 0);
        set_in(0, 6'b000000, 6'h00, 0, 0, 0, 0, 0, 0, 0, 0);

        // Random streams on a small register set to provoke hazards.
        for (int i = 0; i < 3000; i++) begin
            set_in(($urandom_range(0, 49) == 0), pick_op(), pick_funct(), 1'($urandom),
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
